// File: rtl/gate_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gate_pkg
// Brief   : Shared encodings and truth-table constants for the gate exerciser.
// Revision: 1.0 - initial release
// ============================================================================
package gate_pkg;

  localparam int NUM_VECTORS = 4;

  // Expected y per vector index {a,b}; bit i is the result for index i.
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NOR  = 4'b0001;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRIVE  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_SAMPLE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_DRIVE  = ST_DRIVE,
    S_SETTLE = ST_SETTLE,
    S_SAMPLE = ST_SAMPLE,
    S_DONE   = ST_DONE
  } state_t;

  function automatic logic tt_bit(input logic [3:0] tt, input logic [1:0] idx);
    return tt[idx];
  endfunction

endpackage
`default_nettype wire

// File: rtl/gate_exerciser_if.sv
`default_nettype none
// ============================================================================
// Module  : gate_exerciser_if
// Brief   : Control/result and gate-pin bundle between exerciser and its user.
// Revision: 1.0 - initial release
// ============================================================================
interface gate_exerciser_if #(
  parameter int ERR_W = 4
) ();
  logic             start;
  logic [3:0]       truth_table;
  logic             gate_y;
  logic             gate_a;
  logic             gate_b;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [3:0]       fail_vec;

  modport master (
    input  start, truth_table, gate_y,
    output gate_a, gate_b, busy, done, pass, err_count, fail_vec
  );

  modport slave (
    output start, truth_table, gate_y,
    input  gate_a, gate_b, busy, done, pass, err_count, fail_vec
  );
endinterface
`default_nettype wire

// File: rtl/settle_timer.sv
`default_nettype none
// ============================================================================
// Module  : settle_timer
// Brief   : Loadable down-counter that times the settle window; flags zero.
// Revision: 1.0 - initial release
// ============================================================================
module settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_load,
  input  wire logic i_dec,
  output logic      o_zero
);

  localparam int c_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  // Loads N-1 so the zero flag marks the last settle cycle.
  localparam logic [c_W-1:0] c_LOAD = c_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);

  logic [c_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= c_LOAD;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - c_W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/gate_exerciser.sv
`default_nettype none
// ============================================================================
// Module  : gate_exerciser
// Brief   : Sweeps all {a,b} vectors through a 2-input gate and checks y.
// Revision: 1.0 - initial release
// ============================================================================
module gate_exerciser
  import gate_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1,
  parameter int ERR_W         = 4
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  gate_exerciser_if.master bus
);

  localparam int              c_LW        = (LOOPS > 1) ? $clog2(LOOPS) : 1;
  localparam logic [c_LW-1:0] c_LAST_LOOP = c_LW'(LOOPS - 1);

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_index;
  logic [c_LW-1:0]  r_loop;
  logic [3:0]       r_tt;
  logic [ERR_W-1:0] r_err;
  logic [3:0]       r_fail;
  logic             r_pass;

  logic             w_accept;
  logic             w_load;
  logic             w_dec;
  logic             w_sample;
  logic             w_zero;
  logic             w_last;
  logic             w_mismatch;
  logic [ERR_W-1:0] w_err_next;
  logic             w_vec_on;

  settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_dec  (w_dec),
    .o_zero (w_zero)
  );

  assign w_last     = (r_index == 2'd3) && (r_loop == c_LAST_LOOP);
  assign w_mismatch = (bus.gate_y != tt_bit(r_tt, r_index));
  // Saturating increment: the count sticks at all-ones.
  assign w_err_next = (w_mismatch && (r_err != '1)) ? (r_err + ERR_W'(1)) : r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_load   = 1'b0;
    w_dec    = 1'b0;
    w_sample = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = S_DRIVE;
        end
      end
      S_DRIVE: begin
        w_load = 1'b1;
        w_next = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
      end
      S_SETTLE: begin
        if (w_zero) begin
          w_next = S_SAMPLE;
        end else begin
          w_dec = 1'b1;
        end
      end
      S_SAMPLE: begin
        w_sample = 1'b1;
        w_next   = w_last ? S_DONE : S_DRIVE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_index <= 2'd0;
      r_loop  <= '0;
      r_tt    <= 4'd0;
      r_err   <= '0;
      r_fail  <= 4'd0;
      r_pass  <= 1'b0;
    end else if (w_accept) begin
      r_index <= 2'd0;
      r_loop  <= '0;
      r_tt    <= bus.truth_table;
      r_err   <= '0;
      r_fail  <= 4'd0;
      r_pass  <= 1'b0;
    end else if (w_sample) begin
      r_err <= w_err_next;
      if (w_mismatch) begin
        r_fail[r_index] <= 1'b1;
      end
      // Pass is resolved on the way into DONE so it is valid alongside done.
      if (w_last) begin
        r_pass <= (w_err_next == '0);
      end else begin
        r_index <= r_index + 2'd1;
        if (r_index == 2'd3) begin
          r_loop <= r_loop + c_LW'(1);
        end
      end
    end
  end

  assign w_vec_on      = (r_state == S_DRIVE) || (r_state == S_SETTLE) || (r_state == S_SAMPLE);
  assign bus.gate_a    = w_vec_on & r_index[1];
  assign bus.gate_b    = w_vec_on & r_index[0];
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.pass      = r_pass;
  assign bus.err_count = r_err;
  assign bus.fail_vec  = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_gate_exerciser.sv
`default_nettype none
// ============================================================================
// Module  : tb_gate_exerciser
// Brief   : Directed checks of gate_exerciser against modelled gates.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gate_exerciser;
  import gate_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] start_v = 3'b000;
  logic [2:0] glitch_v = 3'b000;
  logic [3:0] tt_v [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gate_exerciser_if #(.ERR_W(4)) if_a ();
  gate_exerciser_if #(.ERR_W(2)) if_b ();
  gate_exerciser_if #(.ERR_W(4)) if_c ();

  gate_exerciser #(.SETTLE_CYCLES(2), .LOOPS(1), .ERR_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.master));
  gate_exerciser #(.SETTLE_CYCLES(2), .LOOPS(3), .ERR_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.master));
  gate_exerciser #(.SETTLE_CYCLES(0), .LOOPS(1), .ERR_W(4)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c.master));

  // a and c exercise a NAND gate; b sees y stuck at 1.
  assign if_a.start       = start_v[0];
  assign if_a.truth_table = tt_v[0];
  assign if_a.gate_y      = ~(if_a.gate_a & if_a.gate_b) ^ glitch_v[0];
  assign if_b.start       = start_v[1];
  assign if_b.truth_table = tt_v[1];
  assign if_b.gate_y      = 1'b1 ^ glitch_v[1];
  assign if_c.start       = start_v[2];
  assign if_c.truth_table = tt_v[2];
  assign if_c.gate_y      = ~(if_c.gate_a & if_c.gate_b) ^ glitch_v[2];

  logic [3:0] obs_vec  [3];
  logic [3:0] obs_err  [3];
  logic [3:0] obs_fail [3];
  logic       obs_pass [3];

  assign obs_vec[0]  = {if_a.gate_a, if_a.gate_b, if_a.busy, if_a.done};
  assign obs_vec[1]  = {if_b.gate_a, if_b.gate_b, if_b.busy, if_b.done};
  assign obs_vec[2]  = {if_c.gate_a, if_c.gate_b, if_c.busy, if_c.done};
  assign obs_err[0]  = if_a.err_count;
  assign obs_err[1]  = {2'b00, if_b.err_count};
  assign obs_err[2]  = if_c.err_count;
  assign obs_fail[0] = if_a.fail_vec;
  assign obs_fail[1] = if_b.fail_vec;
  assign obs_fail[2] = if_c.fail_vec;
  assign obs_pass[0] = if_a.pass;
  assign obs_pass[1] = if_b.pass;
  assign obs_pass[2] = if_c.pass;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // obs_vec layout: {gate_a, gate_b, busy, done}
  task automatic run(input int d, input int s, input int loops, input logic [3:0] tt,
                     input int exp_err, input logic [3:0] exp_fail, input logic exp_pass,
                     input bit pokes, input bit glitch, input string name);
    int         total;
    logic [1:0] idx;
    logic [3:0] expv;
    total = loops * 4 * (s + 2) + 1;
    @(negedge clk);
    start_v[d] = 1'b1;
    tt_v[d]    = tt;
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      if (c < total) begin
        idx  = 2'(((c - 1) / (s + 2)) % 4);
        expv = {idx[1], idx[0], 1'b1, 1'b0};
        chk($sformatf("%s_c%0d_vec", name, c), 32'(obs_vec[d]), 32'(expv));
      end else begin
        chk($sformatf("%s_done_vec", name), 32'(obs_vec[d]), 32'h3);
        chk($sformatf("%s_err", name), 32'(obs_err[d]), 32'(exp_err));
        chk($sformatf("%s_fail", name), 32'(obs_fail[d]), 32'(exp_fail));
        chk($sformatf("%s_pass", name), 32'(obs_pass[d]), 32'(exp_pass));
      end
      start_v[d]  = pokes && (c == 5 || c == 10);
      tt_v[d]     = ~tt;
      glitch_v[d] = glitch && (c < total) && (((c - 1) % (s + 2)) != (s + 1));
    end
    start_v[d]  = 1'b0;
    glitch_v[d] = 1'b0;
    @(negedge clk);
    chk($sformatf("%s_idle_vec", name), 32'(obs_vec[d]), 32'h0);
    chk($sformatf("%s_pass_hold", name), 32'(obs_pass[d]), 32'(exp_pass));
  endtask

  initial begin
    tt_v[0] = 4'd0;
    tt_v[1] = 4'd0;
    tt_v[2] = 4'd0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_vec%0d", d), 32'(obs_vec[d]), 32'h0);
      chk($sformatf("rst_err%0d", d), 32'(obs_err[d]), 32'h0);
      chk($sformatf("rst_fail%0d", d), 32'(obs_fail[d]), 32'h0);
      chk($sformatf("rst_pass%0d", d), 32'(obs_pass[d]), 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    run(0, 2, 1, TT_NAND, 0, 4'b0000, 1'b1, 1'b0, 1'b0, "nand");
    run(0, 2, 1, TT_AND,  4, 4'b1111, 1'b0, 1'b0, 1'b0, "and_on_nand");
    run(1, 2, 3, TT_NAND, 3, 4'b1000, 1'b0, 1'b0, 1'b0, "y1_nand_loops3");
    run(1, 2, 3, TT_AND,  3, 4'b0111, 1'b0, 1'b0, 1'b0, "y1_and_sat");
    run(2, 0, 1, TT_NAND, 0, 4'b0000, 1'b1, 1'b0, 1'b0, "settle0_nand");
    run(2, 0, 1, TT_XOR,  1, 4'b0001, 1'b0, 1'b0, 1'b0, "settle0_xor");
    run(0, 2, 1, TT_NAND, 0, 4'b0000, 1'b1, 1'b1, 1'b1, "pokes_glitch");

    // Abort a run with reset in cycle 7, after vector 0 already mismatched.
    @(negedge clk);
    start_v[0] = 1'b1;
    tt_v[0]    = TT_AND;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
    end
    chk("abort_pre_vec", 32'(obs_vec[0]), 32'h6);
    chk("abort_pre_err", 32'(obs_err[0]), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_vec", 32'(obs_vec[0]), 32'h0);
    chk("abort_err", 32'(obs_err[0]), 32'h0);
    chk("abort_fail", 32'(obs_fail[0]), 32'h0);
    chk("abort_pass", 32'(obs_pass[0]), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("post_abort_idle%0d", c), 32'(obs_vec[0]), 32'h0);
    end
    run(0, 2, 1, TT_NAND, 0, 4'b0000, 1'b1, 1'b0, 1'b0, "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gate_exerciser.md
Name: gate_exerciser

Overview:
- Self-checking sequencer for a 2-input combinational gate (NAND, AND, OR, XOR, ...) instantiated beside it.
- On `start`, drives all four {a,b} input vectors to the gate and waits a programmable settle time after each one.
- Samples the gate output and compares it against a 4-bit expected truth table.
- Reports pass/fail, the error count and a per-vector failure mask. It replaces hand-written pattern benches with a reusable hardware checker.

Parameters:
- SETTLE_CYCLES, 2, idle cycles between driving a vector and sampling `gate_y`; 0 is legal.
- LOOPS, 1, number of full 4-vector sweeps per run; must be ≥ 1.
- ERR_W, 4, width of `err_count`; the counter saturates.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a run; sampled only in IDLE.
- truth_table  input  4  expected output; bit i = expected y for vector index i = {a,b}. NAND = 4'b0111.
- gate_y  input  1  output of the gate under test.
- gate_a  output  1  gate input a (index bit 1).
- gate_b  output  1  gate input b (index bit 0).
- busy  output  1  high from the cycle after `start` is accepted through the DONE cycle.
- done  output  1  one-cycle pulse at the end of a run.
- pass  output  1  high when the last run had zero mismatches; held until the next accepted `start`.
- err_count  output  ERR_W  mismatch count of the last run, saturating.
- fail_vec  output  4  bit i set if vector i mismatched in any loop of the last run.

Behaviour:
- Reset, asynchronous while `rst_n` = 0:
  - state = IDLE.
  - `gate_a`, `gate_b`, `busy`, `done`, `pass` = 0.
  - `err_count` = 0 and `fail_vec` = 0.
  - Internal vector index, loop counter and settle counter = 0.
- States: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE:
  - `gate_a` = `gate_b` = 0 and `busy` = 0.
  - On `start` = 1: latch `truth_table` into an internal register, clear `err_count`, `fail_vec` and `pass`, set index = 0 and loop = 0, then go to DRIVE.
- DRIVE (1 cycle):
  - `gate_a` = index[1], `gate_b` = index[0].
  - Load the settle counter.
  - Next state: SETTLE, or SAMPLE directly if SETTLE_CYCLES = 0.
- SETTLE (SETTLE_CYCLES cycles): hold the vector, count down, then go to SAMPLE.
- SAMPLE (1 cycle), vector held:
  - If `gate_y` ≠ tt_latched[index]: set fail_vec[index] and increment `err_count`. The count saturates at 2^ERR_W − 1 and never wraps.
  - If index = 3 and loop = LOOPS − 1: go to DONE.
  - Otherwise: index += 1 (3 wraps to 0 and loop += 1), then go to DRIVE.
- DONE (1 cycle):
  - `done` = 1 and `busy` = 1.
  - `pass` is set to (err_count == 0 including this run's final sample).
  - `gate_a`/`gate_b` return to 0.
  - Next state: IDLE.
- Latency:
  - Each vector takes SETTLE_CYCLES + 2 cycles.
  - `done` is high in cycle LOOPS·4·(SETTLE_CYCLES + 2) + 1 after the edge that accepted `start`. This is 17 cycles with the defaults.
- `start` while not IDLE is ignored; no queuing.
- `start` held high continuously starts a new run on the cycle after DONE.
- `truth_table` changes mid-run have no effect, because the latched copy is used.
- `gate_y` is sampled only in SAMPLE; glitches during DRIVE/SETTLE are ignored.
- Reset mid-run aborts immediately: outputs take their reset values, no `done` pulse, and results are cleared.

Decomposition:
- Shared package `gate_pkg`:
  - state encoding localparams.
  - NUM_VECTORS = 4.
  - Truth-table constants TT_NAND = 4'b0111, TT_AND = 4'b1000, TT_OR = 4'b1110, TT_XOR = 4'b0110, TT_NOR = 4'b0001.
- One sub-module: `settle_timer`, a loadable down-counter sized by SETTLE_CYCLES with a zero flag, used by the DRIVE/SETTLE states.

Test Plan:
- NAND gate, truth_table = TT_NAND, defaults, `start` pulse → vectors 00, 01, 10, 11 in that order, each held 4 cycles; `done` in cycle 17; `pass` = 1, `err_count` = 0, `fail_vec` = 4'b0000.
- NAND gate, truth_table = TT_AND → `pass` = 0, `err_count` = 4, `fail_vec` = 4'b1111.
- `gate_y` tied to 1, LOOPS = 3, ERR_W = 2, truth_table = TT_NAND → 3 mismatches (vector 3 in each loop); `err_count` = 3 (saturated at max, no wrap), `fail_vec` = 4'b1000; `done` in cycle 49.
- SETTLE_CYCLES = 0, NAND → each vector held 2 cycles; `done` in cycle 9; `pass` = 1.
- `start` re-asserted at cycles 5 and 10 of a run → ignored; exactly one `done`; `busy` stays 1 throughout the run.
- `rst_n` low during cycle 7 of a run → same cycle: `gate_a` = `gate_b` = 0, `busy` = 0, `err_count` = 0; no `done`. A new `start` after release runs normally and passes.
